// File: rtl/afe_pkg.sv
// Shared constants and state encoding for the AFE injection sequencer.
package afe_pkg;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned NINJ_W = 8;

  localparam logic [CNT_W-1:0] TOT_SAT = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INJ_HI = 2'd1,
    INJ_LO = 2'd2,
    FIN    = 2'd3
  } state_t;

endpackage

// File: rtl/afe_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module afe_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/afe_inj_seq.sv
// Charge-injection sequencer: INJ pulse train plus hit count and TOT per scan.
// Define AFE_INJ_TOT_EN to build the TOT counter; otherwise TOT_LAST reads 0.
module afe_inj_seq
  import afe_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_B,
  input  logic              START,
  input  logic              ABORT,
  input  logic [CNT_W-1:0]  PERIOD,
  input  logic [CNT_W-1:0]  WIDTH,
  input  logic [NINJ_W-1:0] NINJ,
  input  logic              COMP,
  output logic              INJ,
  output logic              BUSY,
  output logic              DONE,
  output logic [NINJ_W-1:0] HIT_CNT,
  output logic [CNT_W-1:0]  TOT_LAST
);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  w_r;
  logic [CNT_W-1:0]  l_r;
  logic [NINJ_W-1:0] rem;
  logic [CNT_W-1:0]  w_c;
  logic [CNT_W-1:0]  l_c;
  logic              comp_s;
  logic              comp_d;
  logic              hit_seen;
  logic              start_ok;
  logic              run_ok;
  logic              cyc_end;
  logic              new_hit;

  afe_sync2 u_sync (
    .clk   (CLK),
    .rst_n (RST_B),
    .d     (COMP),
    .q     (comp_s)
  );

  // Effective high/low phase lengths; low phase is never shorter than one cycle.
  always_comb begin
    w_c = (WIDTH == '0) ? CNT_W'(1) : WIDTH;
    l_c = (PERIOD > w_c) ? (PERIOD - w_c) : CNT_W'(1);
  end

  assign start_ok = (state == IDLE) && START && !ABORT;
  assign run_ok   = ((state == INJ_HI) || (state == INJ_LO)) && !ABORT;
  assign cyc_end  = (state == INJ_LO) && (cnt == '0) && !ABORT;
  assign new_hit  = run_ok && comp_s && !comp_d && !hit_seen;

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      state <= IDLE;
      cnt   <= '0;
      w_r   <= '0;
      l_r   <= '0;
      rem   <= '0;
      INJ   <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            if (NINJ != '0) begin
              state <= INJ_HI;
              w_r   <= w_c;
              l_r   <= l_c;
              rem   <= NINJ;
              cnt   <= w_c - CNT_W'(1);
              INJ   <= 1'b1;
              BUSY  <= 1'b1;
            end else begin
              state <= FIN;
              DONE  <= 1'b1;
            end
          end
        end
        INJ_HI: begin
          if (ABORT) begin
            state <= IDLE;
            INJ   <= 1'b0;
            BUSY  <= 1'b0;
          end else if (cnt == '0) begin
            state <= INJ_LO;
            INJ   <= 1'b0;
            cnt   <= l_r - CNT_W'(1);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        INJ_LO: begin
          if (ABORT) begin
            state <= IDLE;
            INJ   <= 1'b0;
            BUSY  <= 1'b0;
          end else if (cnt == '0) begin
            if (rem > NINJ_W'(1)) begin
              state <= INJ_HI;
              INJ   <= 1'b1;
              cnt   <= w_r - CNT_W'(1);
              rem   <= rem - NINJ_W'(1);
            end else begin
              state <= FIN;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // One hit per injection cycle, on the first comp_s rising edge.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      comp_d   <= 1'b0;
      hit_seen <= 1'b0;
      HIT_CNT  <= '0;
    end else begin
      comp_d <= comp_s;
      if (start_ok) begin
        hit_seen <= 1'b0;
        HIT_CNT  <= '0;
      end else if (run_ok) begin
        if (new_hit) HIT_CNT <= HIT_CNT + NINJ_W'(1);
        if (cyc_end)      hit_seen <= 1'b0;
        else if (new_hit) hit_seen <= 1'b1;
      end
    end
  end

`ifdef AFE_INJ_TOT_EN
  logic [CNT_W-1:0] tot;
  logic [CNT_W-1:0] tot_nx;
  logic             tot_run;
  logic [CNT_W-1:0] tot_last;

  // TOT including the current sample, so the cycle-end edge is counted too.
  always_comb begin
    tot_nx = tot;
    if (new_hit)                tot_nx = CNT_W'(1);
    else if (tot_run && comp_s) tot_nx = (tot == TOT_SAT) ? tot : tot + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      tot      <= '0;
      tot_run  <= 1'b0;
      tot_last <= '0;
    end else if (start_ok) begin
      tot      <= '0;
      tot_run  <= 1'b0;
      tot_last <= '0;
    end else if (run_ok) begin
      if (cyc_end) begin
        tot     <= '0;
        tot_run <= 1'b0;
        if (hit_seen || new_hit) tot_last <= tot_nx;
      end else begin
        tot     <= tot_nx;
        tot_run <= new_hit || (tot_run && comp_s);
      end
    end
  end

  assign TOT_LAST = tot_last;
`else
  assign TOT_LAST = '0;
`endif

endmodule

// File: tb/tb_afe_inj_seq.sv
// Directed vector bench for afe_inj_seq: scan timing, hits, TOT, abort, reset.
module tb_afe_inj_seq;

  logic        CLK = 1'b0;
  logic        RST_B;
  logic        START;
  logic        ABORT;
  logic [15:0] PERIOD;
  logic [15:0] WIDTH;
  logic [7:0]  NINJ;
  logic        COMP;
  logic        INJ;
  logic        BUSY;
  logic        DONE;
  logic [7:0]  HIT_CNT;
  logic [15:0] TOT_LAST;

  int n_chk  = 0;
  int n_fail = 0;

  afe_inj_seq dut (
    .CLK      (CLK),
    .RST_B    (RST_B),
    .START    (START),
    .ABORT    (ABORT),
    .PERIOD   (PERIOD),
    .WIDTH    (WIDTH),
    .NINJ     (NINJ),
    .COMP     (COMP),
    .INJ      (INJ),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .HIT_CNT  (HIT_CNT),
    .TOT_LAST (TOT_LAST)
  );

  always #5 CLK = ~CLK;

  // period/width/ninj in; COMP high at phases coff+1..coff+clen of each cycle;
  // w, l, done cycle, hits and TOT worked out by hand.
  typedef struct {
    int period; int width; int ninj; int coff; int clen;
    int w; int l; int exp_done; int exp_hit; int exp_tot;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  function automatic int tot_exp(input int t);
`ifdef AFE_INJ_TOT_EN
    return t;
`else
    return 0 * t;
`endif
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_scan(input vec_t v, input int idx);
    int per, span, p, j, bad_inj, bad_busy, done_cnt, done_at;
    logic inj_e, busy_e;
    per = v.w + v.l;
    span = v.ninj * per;
    bad_inj = 0; bad_busy = 0; done_cnt = 0; done_at = -1;
    PERIOD = 16'(v.period);
    WIDTH  = 16'(v.width);
    NINJ   = 8'(v.ninj);
    START  = 1'b1;
    step();
    START = 1'b0;
    for (int k = 1; k <= span + 4; k++) begin
      p = (k - 1) % per + 1;
      j = (k - 1) / per;
      COMP   = (j < v.ninj) && (p > v.coff) && (p <= v.coff + v.clen);
      inj_e  = (k <= span) && (p <= v.w);
      busy_e = (k <= span);
      if (INJ !== inj_e) bad_inj++;
      if (BUSY !== busy_e) bad_busy++;
      if (DONE === 1'b1) begin
        done_cnt++;
        done_at = k;
      end
      step();
    end
    COMP = 1'b0;
    chk($sformatf("v%0d inj_bad_cycles", idx), bad_inj, 0);
    chk($sformatf("v%0d busy_bad_cycles", idx), bad_busy, 0);
    chk($sformatf("v%0d done_pulses", idx), done_cnt, 1);
    chk($sformatf("v%0d done_cycle", idx), done_at, v.exp_done);
    chk($sformatf("v%0d hit_cnt", idx), int'(HIT_CNT), v.exp_hit);
    chk($sformatf("v%0d tot_last", idx), int'(TOT_LAST), tot_exp(v.exp_tot));
  endtask

  initial begin
    int bad;
    vecs[0] = '{10, 4, 3, 0, 0, 4, 6, 31, 0, 0};
    vecs[1] = '{10, 4, 0, 0, 0, 4, 6, 1, 0, 0};
    vecs[2] = '{10, 4, 4, 2, 5, 4, 6, 41, 4, 5};
    vecs[3] = '{0, 0, 2, 0, 0, 1, 1, 5, 0, 0};
    vecs[4] = '{3, 5, 2, 0, 1, 5, 1, 13, 2, 1};
    vecs[5] = '{8, 2, 2, 6, 2, 2, 6, 17, 1, 2};

    RST_B = 1'b0; START = 1'b0; ABORT = 1'b0; COMP = 1'b0;
    PERIOD = '0; WIDTH = '0; NINJ = '0;
    step(); step();
    chk("reset inj", int'(INJ), 0);
    chk("reset busy", int'(BUSY), 0);
    chk("reset done", int'(DONE), 0);
    chk("reset hit_cnt", int'(HIT_CNT), 0);
    chk("reset tot_last", int'(TOT_LAST), 0);
    RST_B = 1'b1;
    step(); step();

    for (int i = 0; i < 6; i++) run_scan(vecs[i], i);

    // Abort in the 2nd INJ high after a hit in cycle 1; a START mid-scan is ignored.
    PERIOD = 16'd10; WIDTH = 16'd4; NINJ = 8'd3; START = 1'b1;
    step();
    START = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      COMP = (k >= 3) && (k <= 7);
      if (k == 3) begin
        START = 1'b1; NINJ = 8'd1; PERIOD = 16'd2; WIDTH = 16'd1;
      end
      if (k == 4) begin
        START = 1'b0;
        chk("abort_seq inj_k4", int'(INJ), 1);
      end
      if (k == 11) chk("abort_seq inj_k11", int'(INJ), 1);
      if (k == 12) ABORT = 1'b1;
      step();
    end
    ABORT = 1'b0;
    chk("abort inj_next", int'(INJ), 0);
    chk("abort busy_next", int'(BUSY), 0);
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      if (DONE !== 1'b0 || INJ !== 1'b0 || BUSY !== 1'b0) bad++;
      step();
    end
    chk("abort quiet_bad_cycles", bad, 0);
    chk("abort hit_cnt", int'(HIT_CNT), 1);
    chk("abort tot_last", int'(TOT_LAST), tot_exp(5));

    // ABORT beats START from IDLE: no scan, counters untouched.
    PERIOD = 16'd10; WIDTH = 16'd4; NINJ = 8'd3; START = 1'b1; ABORT = 1'b1;
    step();
    START = 1'b0; ABORT = 1'b0;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (DONE !== 1'b0 || INJ !== 1'b0 || BUSY !== 1'b0) bad++;
      step();
    end
    chk("abort_start bad_cycles", bad, 0);
    chk("abort_start hit_cnt", int'(HIT_CNT), 1);

    // Asynchronous reset while INJ is high, then a normal scan.
    PERIOD = 16'd10; WIDTH = 16'd4; NINJ = 8'd2; START = 1'b1;
    step();
    START = 1'b0;
    for (int k = 1; k < 12; k++) begin
      COMP = (k >= 3) && (k <= 7);
      step();
    end
    chk("rst_seq inj_before", int'(INJ), 1);
    chk("rst_seq hit_before", int'(HIT_CNT), 1);
    #2 RST_B = 1'b0;
    #1;
    chk("rst_async inj", int'(INJ), 0);
    chk("rst_async busy", int'(BUSY), 0);
    chk("rst_async hit_cnt", int'(HIT_CNT), 0);
    chk("rst_async tot_last", int'(TOT_LAST), 0);
    step(); step();
    RST_B = 1'b1;
    step();
    run_scan(vecs[2], 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/afe_inj_seq.md
# afe_inj_seq

Injection sequencer for the AFE test board CPLD. Drives the charge-injection strobe (INJ) with a programmable pulse width, period and repetition count, samples the asynchronous discriminator output COMP, and accumulates hit count and time-over-threshold (TOT) per scan. It sits between the SPI register bank, which supplies the configuration and START/ABORT, and the AFE front-end pins.

## Interface
- CNT_W, 16: width of the period, width and TOT counters.
- NINJ_W, 8: width of the repetition count and the hit counter.

- CLK  in  1  system clock (40 MHz board clock).
- RST_B  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle request to begin a scan.
- ABORT  in  1  one-cycle request to stop a running scan.
- PERIOD  in  CNT_W  injection period in CLK cycles.
- WIDTH  in  CNT_W  INJ high time in CLK cycles.
- NINJ  in  NINJ_W  number of injections per scan.
- COMP  in  1  asynchronous discriminator output.
- INJ  out  1  injection strobe, registered.
- BUSY  out  1  scan in progress.
- DONE  out  1  one-cycle pulse at normal scan completion.
- HIT_CNT  out  NINJ_W  injections with a detected hit in the current or last scan.
- TOT_LAST  out  CNT_W  TOT of the most recent hit, in CLK cycles.

## Operation
- States: IDLE, INJ_HI, INJ_LO, FIN.
- IDLE: START with NINJ≠0 latches PERIOD, WIDTH and NINJ, clears HIT_CNT and TOT_LAST, and moves to INJ_HI. START with NINJ=0 goes to FIN with no pulse.
- INJ_HI: INJ=1 for w = max(WIDTH,1) cycles, then INJ_LO.
- INJ_LO: INJ=0 for l = max(PERIOD−w,1) cycles. At the end of this phase, go to INJ_HI if injections remain, else FIN.
- FIN: DONE=1 for one cycle, then IDLE.
- COMP passes through a 2-FF synchronizer giving comp_s. An injection cycle spans INJ_HI plus INJ_LO.
- Hit: the first rising edge of comp_s within an injection cycle increments HIT_CNT once. Further edges in the same cycle are ignored.
- TOT: counts cycles comp_s is high, starting at the first rising edge in the cycle. It stops at the falling edge or at the end of the cycle. It saturates at 2^CNT_W−1. TOT_LAST updates at the end of every cycle that had a hit.
- START while BUSY is ignored. Configuration inputs are ignored while BUSY.
- ABORT while BUSY: next cycle INJ=0, BUSY=0, state IDLE, no DONE pulse. HIT_CNT and TOT_LAST keep their partial values.
- ABORT and START in the same cycle from IDLE: ABORT wins and no scan starts.
- HIT_CNT cannot overflow because it is at most NINJ.

## Timing
- Reset values: INJ=0, BUSY=0, DONE=0, HIT_CNT=0, TOT_LAST=0, state IDLE, synchronizer flops 0. Reset is effective immediately, including mid-scan.
- START sampled at edge t gives INJ=1 and BUSY=1 from t+1.
- INJ is high exactly w cycles and low exactly l cycles, so each injection cycle lasts w+l cycles.
- Scan latency: DONE is asserted at t+1+NINJ·(w+l). BUSY deasserts in the same cycle DONE asserts.
- NINJ=0: DONE at t+1 and BUSY never asserted.
- COMP to comp_s latency is 2 cycles. COMP edges in the last 2 cycles of an injection cycle are credited to the next cycle, or lost after the final cycle.

## Configuration
- AFE_INJ_TOT_EN defined: TOT counter and TOT_LAST are implemented as described.
- AFE_INJ_TOT_EN undefined: TOT logic is removed, TOT_LAST is tied to 0, and hit counting is unchanged.

## Structure
- Package afe_pkg holds:
  - the state encoding (IDLE, INJ_HI, INJ_LO, FIN);
  - the default CNT_W and NINJ_W constants;
  - the saturation constant for TOT.
- Sub-module afe_sync2: a 2-FF synchronizer with asynchronous active-low reset, used for COMP.

## Test plan
- PERIOD=10, WIDTH=4, NINJ=3, COMP=0, START at t → INJ high t+1..t+4, low t+5..t+10, three pulses; DONE at t+31; HIT_CNT=0.
- Same configuration, NINJ=4, COMP high for 5 cycles starting 2 cycles after each INJ rise → HIT_CNT=4, TOT_LAST=5, DONE at t+41.
- NINJ=0, START → DONE at t+1, INJ and BUSY never high, HIT_CNT=0.
- PERIOD=0, WIDTH=0, NINJ=2 → INJ pattern 1,0,1,0 starting t+1; DONE at t+5.
- ABORT during the 2nd INJ high, COMP hit in the 1st cycle → INJ=0 and BUSY=0 next cycle, no DONE, HIT_CNT=1; START during BUSY earlier is ignored.
- RST_B low mid-scan with INJ=1 → INJ, BUSY, HIT_CNT and TOT_LAST go to 0 without a clock edge; after release, a new START runs normally.
